// File: rtl/video_pkg.sv
// Shared timing defaults, colour palette and enums for the video test-pattern source.
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [23:0] DEF_SOLID_RGB = 24'hC8C8C8;
  localparam logic [23:0] RGB_BLACK     = 24'h000000;
  localparam logic [23:0] RGB_WHITE     = 24'hFFFFFF;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_GREY    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Entry 0 is the leftmost bar; listed here from highest index down.
  localparam logic [7:0][23:0] BAR_PALETTE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return BAR_PALETTE[idx];
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters, RUN/IDLE control and the active/sync decodes.
module video_timing_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic [HW-1:0] hcnt,
  output logic          vtile,
  output logic          active,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          frame_start,
  output logic          load_pattern
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  run_state_e    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          live_q, live_d;

  // live_q stays low for the first RUN cycle so pixel (0,0) is presented a cycle later.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    live_d       = live_q;
    load_pattern = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        live_d = 1'b0;
        if (enable) begin
          state_d      = ST_RUN;
          load_pattern = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
          vcnt_d  = '0;
          live_d  = 1'b0;
        end else if (!live_q) begin
          live_d = 1'b1;
        end else if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          if (vcnt_q == V_LAST) begin
            vcnt_d       = '0;
            load_pattern = 1'b1;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      live_q  <= live_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vtile       = vcnt_q[5];
  assign active      = live_q && (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
  assign hsync_on    = live_q && (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign vsync_on    = live_q && (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  assign frame_start = live_q && (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/video_pattern_source.sv
// Video timing and test-pattern generator: raster counters plus pattern
// generation and a registered pixel-stream output.
module video_pattern_source
  import video_pkg::*;
#(
  parameter int          H_ACTIVE        = DEF_H_ACTIVE,
  parameter int          H_FP            = DEF_H_FP,
  parameter int          H_SYNC          = DEF_H_SYNC,
  parameter int          H_BP            = DEF_H_BP,
  parameter int          V_ACTIVE        = DEF_V_ACTIVE,
  parameter int          V_FP            = DEF_V_FP,
  parameter int          V_SYNC          = DEF_V_SYNC,
  parameter int          V_BP            = DEF_V_BP,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter logic [23:0] SOLID_RGB       = DEF_SOLID_RGB,
  localparam int         H_TOTAL         = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int         HW              = $clog2(H_TOTAL)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Enable,
  input  logic [1:0]  PatternSel,
  output logic        HSync,
  output logic        VSync,
  output logic        DataEnable,
  output logic [23:0] RGBout,
  output logic        FrameStart
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [HW-1:0] hcnt;
  logic          vtile;
  logic          active;
  logic          hsync_on;
  logic          vsync_on;
  logic          frame_start;
  logic          load_pattern;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (CLK),
    .rst          (RST),
    .enable       (Enable),
    .hcnt         (hcnt),
    .vtile        (vtile),
    .active       (active),
    .hsync_on     (hsync_on),
    .vsync_on     (vsync_on),
    .frame_start  (frame_start),
    .load_pattern (load_pattern)
  );

  pattern_e      pat_q, pat_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          fs_q, fs_d;
  logic [HW-1:0] bar_idx;
  logic [23:0]   pixel;

  // Pixels past the eighth bar (when H_ACTIVE is not a multiple of 8) are black.
  always_comb begin
    bar_idx = hcnt / HW'(BAR_W);
    pixel   = RGB_BLACK;
    case (pat_q)
      PAT_BARS:    pixel = (bar_idx < HW'(8)) ? bar_colour(bar_idx[2:0]) : RGB_BLACK;
      PAT_GREY:    pixel = {3{hcnt[7:0]}};
      PAT_CHECKER: pixel = (hcnt[5] ^ vtile) ? RGB_WHITE : RGB_BLACK;
      PAT_SOLID:   pixel = SOLID_RGB;
      default:     pixel = RGB_BLACK;
    endcase
  end

  always_comb begin
    pat_d   = load_pattern ? pattern_e'(PatternSel) : pat_q;
    hsync_d = hsync_on ^ SYNC_ACTIVE_LOW;
    vsync_d = vsync_on ^ SYNC_ACTIVE_LOW;
    de_d    = active;
    rgb_d   = active ? pixel : RGB_BLACK;
    fs_d    = frame_start;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q   <= PAT_BARS;
      hsync_q <= SYNC_ACTIVE_LOW;
      vsync_q <= SYNC_ACTIVE_LOW;
      de_q    <= 1'b0;
      rgb_q   <= RGB_BLACK;
      fs_q    <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end

  assign HSync      = hsync_q;
  assign VSync      = vsync_q;
  assign DataEnable = de_q;
  assign RGBout     = rgb_q;
  assign FrameStart = fs_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Bench for video_pattern_source on a shortened raster, checked cycle by cycle
// against a frame-position reference model plus fixed pixel vectors.
module tb_video_pattern_source;

  localparam int HA = 640, HFP = 2, HSW = 4, HBP = 2;
  localparam int VA = 33,  VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Enable;
  logic [1:0]  PatternSel;
  logic        HSync;
  logic        VSync;
  logic        DataEnable;
  logic [23:0] RGBout;
  logic        FrameStart;

  video_pattern_source #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .SYNC_ACTIVE_LOW (1'b1), .SOLID_RGB (24'hC8C8C8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Enable     (Enable),
    .PatternSel (PatternSel),
    .HSync      (HSync),
    .VSync      (VSync),
    .DataEnable (DataEnable),
    .RGBout     (RGBout),
    .FrameStart (FrameStart)
  );

  always #5 CLK = ~CLK;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: tracks how many edges have passed since the generator started.
  bit          mRun = 1'b0;
  int          mK   = 0;
  int          mPat = 0;
  bit          expLive = 1'b0;
  int          expH = 0, expV = 0;
  logic        expHs = 1'b1, expVs = 1'b1, expDe = 1'b0, expFs = 1'b0;
  logic [23:0] expRgb = 24'h0;
  logic [23:0] barTable [8];

  typedef struct {
    logic [1:0]  sel;
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        de;
  } vec_t;
  vec_t vecs [12];

  logic [1:0] curSel;
  bit         haveRun;
  logic [1:0] selNow;
  bit         enR;
  bit         rstR;
  int         fsCount, lastFs, posInFrame;
  int         deFrame, deLine0, vsLow, vsFirst, hsLow0, hsFirst;

  function automatic logic [23:0] refPixel(int pat, int h, int v);
    logic [7:0] g;
    int idx;
    case (pat)
      0: begin
        idx = h / (HA / 8);
        return (idx < 8) ? barTable[idx] : 24'h000000;
      end
      1: begin
        g = 8'(h % 256);
        return {g, g, g};
      end
      2: return ((((h / 32) + (v / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      default: return 24'hC8C8C8;
    endcase
  endfunction

  // Outputs after an edge describe the model position held before that edge.
  task automatic modelStep(bit rst, bit en, int sel);
    int t;
    expLive = 1'b0;
    if (!rst && mRun && mK >= 1) begin
      t = mK - 1;
      expLive = 1'b1;
      expH = t % HT;
      expV = (t / HT) % VT;
    end
    if (expLive) begin
      expHs  = !(expH >= HA + HFP && expH < HA + HFP + HSW);
      expVs  = !(expV >= VA + VFP && expV < VA + VFP + VSW);
      expDe  = (expH < HA) && (expV < VA);
      expRgb = expDe ? refPixel(mPat, expH, expV) : 24'h0;
      expFs  = (expH == 0) && (expV == 0);
    end else begin
      expHs = 1'b1; expVs = 1'b1; expDe = 1'b0; expRgb = 24'h0; expFs = 1'b0;
    end
    if (rst || !en) begin
      mRun = 1'b0;
    end else if (!mRun) begin
      mRun = 1'b1;
      mK   = 0;
      mPat = sel;
    end else begin
      mK++;
      if (mK > 1 && ((mK - 1) % FRAME) == 0) mPat = sel;
    end
  endtask

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("hsync", 32'(HSync), 32'(expHs));
    checkValue("vsync", 32'(VSync), 32'(expVs));
    checkValue("de",    32'(DataEnable), 32'(expDe));
    checkValue("rgb",   32'(RGBout), 32'(expRgb));
    checkValue("fs",    32'(FrameStart), 32'(expFs));
  endtask

  task automatic applyStimulus(bit rst, bit en, logic [1:0] sel);
    @(negedge CLK);
    RST = rst;
    Enable = en;
    PatternSel = sel;
    @(posedge CLK);
    modelStep(rst, en, int'(sel));
    #1;
    checkOutput();
  endtask

  task automatic runTo(int x, int y, logic [1:0] sel);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b1, sel);
      n++;
    end while (!(expLive && expH == x && expV == y) && n < 40000);
    if (!(expLive && expH == x && expV == y)) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL runTo(%0d,%0d): actual timeout after %0d cycles required position reached", x, y, n);
    end
  endtask

  initial begin
    barTable = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    vecs[0]  = '{2'd0,   0,  0, 24'hFFFFFF, 1'b1};
    vecs[1]  = '{2'd0,  80,  0, 24'hFFFF00, 1'b1};
    vecs[2]  = '{2'd0, 479,  0, 24'hFF0000, 1'b1};
    vecs[3]  = '{2'd0, 639,  0, 24'h000000, 1'b1};
    vecs[4]  = '{2'd0, 640,  0, 24'h000000, 1'b0};
    vecs[5]  = '{2'd1, 100,  0, 24'h646464, 1'b1};
    vecs[6]  = '{2'd1, 255,  0, 24'hFFFFFF, 1'b1};
    vecs[7]  = '{2'd1, 256,  0, 24'h000000, 1'b1};
    vecs[8]  = '{2'd2,  31,  0, 24'h000000, 1'b1};
    vecs[9]  = '{2'd2,  32,  0, 24'hFFFFFF, 1'b1};
    vecs[10] = '{2'd2,   0, 32, 24'hFFFFFF, 1'b1};
    vecs[11] = '{2'd2,  32, 32, 24'h000000, 1'b1};

    RST = 1'b1;
    Enable = 1'b0;
    PatternSel = 2'd0;

    // Reset dominates a high Enable.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 2'd0);
    checkValue("reset_hsync", 32'(HSync), 32'd1);
    checkValue("reset_vsync", 32'(VSync), 32'd1);
    checkValue("reset_de",    32'(DataEnable), 32'd0);
    checkValue("reset_rgb",   32'(RGBout), 32'd0);
    checkValue("reset_fs",    32'(FrameStart), 32'd0);

    $display("[TB] pixel vector table");
    haveRun = 1'b0;
    curSel = 2'd0;
    for (int i = 0; i < 12; i++) begin
      if (!haveRun || vecs[i].sel != curSel) begin
        applyStimulus(1'b0, 1'b0, vecs[i].sel);
        curSel = vecs[i].sel;
        haveRun = 1'b1;
      end
      runTo(vecs[i].x, vecs[i].y, curSel);
      checkValue($sformatf("vec%0d_rgb", i), 32'(RGBout), 32'(vecs[i].rgb));
      checkValue($sformatf("vec%0d_de", i), 32'(DataEnable), 32'(vecs[i].de));
    end

    $display("[TB] full frame with pattern switch mid-frame");
    applyStimulus(1'b0, 1'b0, 2'd0);
    selNow = 2'd0;
    fsCount = 0; lastFs = 0; deFrame = 0; deLine0 = 0;
    vsLow = 0; vsFirst = -1; hsLow0 = 0; hsFirst = -1;
    for (int c = 0; c < FRAME + HT + 4; c++) begin
      if (expLive && expV == 10) selNow = 2'd3;
      applyStimulus(1'b0, 1'b1, selNow);
      if (FrameStart) begin
        fsCount++;
        checkValue("fs_with_de", 32'(DataEnable), 32'd1);
        if (fsCount == 2) begin
          checkValue("frame_length", 32'(c - lastFs), 32'(FRAME));
          checkValue("frame2_px00", 32'(RGBout), 32'hC8C8C8);
        end
        lastFs = c;
      end
      posInFrame = c - lastFs;
      if (fsCount == 1) begin
        if (DataEnable) deFrame++;
        if (!VSync) begin
          vsLow++;
          if (vsFirst < 0) vsFirst = posInFrame;
        end
        if (posInFrame < HT) begin
          if (DataEnable) deLine0++;
          if (!HSync) begin
            hsLow0++;
            if (hsFirst < 0) hsFirst = posInFrame;
          end
        end
        if (posInFrame == 20 * HT)
          checkValue("bars_kept_after_switch", 32'(RGBout), 32'hFFFFFF);
      end
      if (fsCount == 2 && posInFrame == 80)
        checkValue("frame2_px80", 32'(RGBout), 32'hC8C8C8);
    end
    checkValue("fs_per_frame", 32'(fsCount), 32'd2);
    checkValue("de_per_frame", 32'(deFrame), 32'(HA * VA));
    checkValue("de_per_line",  32'(deLine0), 32'(HA));
    checkValue("hs_low_cycles", 32'(hsLow0), 32'(HSW));
    checkValue("hs_low_start",  32'(hsFirst), 32'(HA + HFP));
    checkValue("vs_low_cycles", 32'(vsLow), 32'(VSW * HT));
    checkValue("vs_low_start",  32'(vsFirst), 32'((VA + VFP) * HT));

    $display("[TB] enable drop at (300,5) and restart");
    applyStimulus(1'b0, 1'b0, 2'd0);
    runTo(300, 5, 2'd0);
    applyStimulus(1'b0, 1'b0, 2'd0);
    checkValue("drop_edge_de",  32'(DataEnable), 32'd1);
    checkValue("drop_edge_rgb", 32'(RGBout), 32'h00FF00);
    applyStimulus(1'b0, 1'b0, 2'd0);
    checkValue("drop_idle_de",    32'(DataEnable), 32'd0);
    checkValue("drop_idle_rgb",   32'(RGBout), 32'd0);
    checkValue("drop_idle_hsync", 32'(HSync), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd0);
    checkValue("restart1_de", 32'(DataEnable), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd0);
    checkValue("restart2_fs", 32'(FrameStart), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd0);
    checkValue("restart3_fs",  32'(FrameStart), 32'd1);
    checkValue("restart3_rgb", 32'(RGBout), 32'hFFFFFF);

    $display("[TB] reset while HSync asserted");
    applyStimulus(1'b0, 1'b0, 2'd3);
    runTo(HA + HFP + 1, 1, 2'd3);
    checkValue("hsync_before_rst", 32'(HSync), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'd3);
    checkValue("rst_hsync", 32'(HSync), 32'd1);
    checkValue("rst_de",    32'(DataEnable), 32'd0);
    checkValue("rst_rgb",   32'(RGBout), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd3);
    checkValue("post_rst2_fs", 32'(FrameStart), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd3);
    checkValue("post_rst3_fs",  32'(FrameStart), 32'd1);
    checkValue("post_rst3_rgb", 32'(RGBout), 32'hC8C8C8);

    $display("[TB] randomized enable/select/reset");
    enR = 1'b1;
    selNow = 2'd0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 399) == 0) enR = !enR;
      if ($urandom_range(0, 149) == 0) selNow = 2'($urandom_range(0, 3));
      rstR = ($urandom_range(0, 1499) == 0);
      applyStimulus(rstR, enR, selNow);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/video_pattern_source.md
# video_pattern_source

Synchronous video timing and test-pattern generator that produces the pixel stream (24-bit RGB, HSync, VSync, DataEnable) consumed by the image filter chain. It is the transmitting end of the pixel-stream interface and lets the filter pipeline be exercised on-chip without a camera or HDMI input. It is a drop-in source for the filter chain's `RGBin`/`HSync` inputs.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch, sync, back porch (pixels)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch, sync, back porch (lines)
- `SYNC_ACTIVE_LOW`, 1: 1 = HSync/VSync driven low while asserted
- `SOLID_RGB`, 24'hC8C8C8: colour for pattern 3
- `CLK`  in  1: pixel clock
- `RST`  in  1: synchronous, active-high reset
- `Enable`  in  1: 1 = generate frames; 0 = idle
- `PatternSel`  in  2: 0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
- `HSync`  out  1: horizontal sync, polarity per `SYNC_ACTIVE_LOW`
- `VSync`  out  1: vertical sync, polarity per `SYNC_ACTIVE_LOW`
- `DataEnable`  out  1: 1 during visible pixels
- `RGBout`  out  24: {R[23:16], G[15:8], B[7:0]}; 0 when `DataEnable`=0
- `FrameStart`  out  1: one-cycle pulse coincident with pixel (0,0)

## Operation
- Totals: `H_TOTAL`=H_ACTIVE+H_FP+H_SYNC+H_BP, `V_TOTAL` likewise. Counters `hcnt` (0..H_TOTAL-1) and `vcnt` (0..V_TOTAL-1) are sized by $clog2 of the totals.
- `hcnt` increments every cycle while running and wraps to 0 at H_TOTAL-1. `vcnt` increments on each `hcnt` wrap and wraps to 0 at V_TOTAL-1 (on the same cycle that `hcnt` wraps).
- States: IDLE, RUN.
  - IDLE: counters = 0; outputs at inactive levels.
  - IDLE→RUN on `Enable`=1. The first generated pixel is (0,0).
  - RUN→IDLE on `Enable`=0 at any point, including mid-line or mid-frame. No frame completion; the next start is at (0,0).
- Active region: `hcnt`<H_ACTIVE and `vcnt`<V_ACTIVE.
- HSync asserted for H_ACTIVE+H_FP ≤ `hcnt` < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
- VSync asserted for V_ACTIVE+V_FP ≤ `vcnt` < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Pattern select: `PatternSel` is latched when entering RUN and at every (0,0). Mid-frame changes take effect next frame.
- Patterns, with x=`hcnt`, y=`vcnt`:
  - 0: eight bars, bar index = x / (H_ACTIVE/8) (integer); colours white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. Any remainder pixels beyond 8 bars are black.
  - 1: R=G=B=x[7:0] (wraps every 256 pixels).
  - 2: white if x[5]^y[5], else black (32×32 squares).
  - 3: `SOLID_RGB`.

## Timing
- All outputs are registered. Outputs for counter position (h,v) appear one cycle after the counters hold (h,v).
- Latency: `Enable` sampled high at edge N puts counters at (0,0) at N+1. `DataEnable`=1, `FrameStart`=1 and pixel (0,0) appear after edge N+2.
- `Enable` low at edge N gives inactive outputs after edge N+1.
- Reset values: `HSync`=`VSync`=inactive level (1 when `SYNC_ACTIVE_LOW`), `DataEnable`=0, `RGBout`=0, `FrameStart`=0; state IDLE; latched pattern = 0.
- `RST` overrides `Enable`. Reset mid-frame gives the reset values at the next edge.

## Structure
- Package `video_pkg`: 640×480 default timing constants, the colour-bar palette, and a pattern-select enum.
- Sub-module `video_timing_counter`: owns `hcnt`/`vcnt`, the active/sync decodes and the RUN/IDLE control. The top level adds pattern generation and the output register.

## Test plan
- Reset, then `Enable`=1 with defaults: exactly 525 VSync-bounded lines of 800 cycles each; 640 DE cycles per visible line; HSync low for 96 cycles starting at line cycle 656; VSync low for lines 490–491.
- Pattern 0: pixel x=0 → FFFFFF; x=80 → FFFF00; x=639 → 000000; DE low → RGBout=0.
- Pattern 1: x=255 → FFFFFF; x=256 → 000000. Pattern 2: (31,0) → 000000; (32,0) → FFFFFF; (32,32) → 000000.
- Change `PatternSel` from 0 to 3 at line 100: the remainder of the frame stays bars; the next frame is C8C8C8; `FrameStart` pulses once per frame, in the same cycle as the first DE of the frame.
- Drop `Enable` at (300,200), then raise it 5 cycles later: outputs go inactive one cycle after the drop; the restart produces FrameStart with pixel (0,0).
- Assert `RST` mid-line while HSync is active: the next edge gives HSync=1, DE=0, RGBout=0; with `Enable` held high, the generator restarts at (0,0) after `RST` is released.
